uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo_pkg.sv | 33 +++
 rtl/uart_rx_fifo_if.sv | 20 ++
 rtl/uart_rx_fifo_sync_fifo.sv | 54 +++++
 rtl/uart_rx_fifo.sv | 109 ++++++++++
 tb/tb_uart_rx_fifo.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and register bit positions for the UART receive FIFO.
package uart_rx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_ACK,
        ST_SETTLE
    } drain_state_e;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_COUNT_LSB = 8;

    localparam int CTRL_CLR_OVF   = 0;
    localparam int CTRL_FLUSH     = 1;

    function automatic logic [31:0] status_word(input logic [7:0] count,
                                                input logic       overflow,
                                                input logic       full,
                                                input logic       empty);
        logic [31:0] w;
        w = '0;
        w[STAT_COUNT_LSB +: 8] = count;
        w[STAT_OVERFLOW]       = overflow;
        w[STAT_FULL]           = full;
        w[STAT_EMPTY]          = empty;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// CPU-side IO request/response bus: master issues requests, slave responds a cycle later.
interface uart_rx_fifo_if;
    logic [31:0] rw_address;
    logic [31:0] read_data;
    logic        read_request;
    logic        read_response;
    logic [7:0]  write_data;
    logic        write_request;
    logic        write_response;

    modport master (
        output rw_address, read_request, write_data, write_request,
        input  read_data, read_response, write_response
    );

    modport slave (
        input  rw_address, read_request, write_data, write_request,
        output read_data, read_response, write_response
    );
endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock FIFO with combinational head; flush overrides push and pop.
module sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    // Refusal uses the pre-cycle full flag, so a same-cycle pop never makes room.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock)
        if (do_push) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Drains UART bytes into a FIFO and exposes it to the CPU with data/status registers and a level irq.
module uart_rx_fifo #(
    parameter int          FIFO_DEPTH        = 16,
    parameter int          IRQ_THRESHOLD     = 1,
    parameter logic [31:0] UART_READ_ADDRESS = 32'h80000004,
    parameter logic [31:0] DATA_ADDRESS      = 32'h80000010,
    parameter logic [31:0] STATUS_ADDRESS    = 32'h80000014
) (
    input  logic          clock,
    input  logic          reset_n,
    output logic [31:0]   uart_rw_address,
    output logic          uart_read_request,
    input  logic [31:0]   uart_read_data,
    input  logic          uart_read_response,
    input  logic          uart_irq,
    output logic          uart_irq_response,
    uart_rx_fifo_if.slave bus,
    output logic          rx_irq
);
    import uart_rx_fifo_pkg::*;

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] IRQ_LEVEL = IRQ_THRESHOLD[AW:0];

    drain_state_e state, state_next;
    logic         push, pop, flush, clr_ovf, overflow;
    logic         rd_data_hit, rd_status_hit, wr_status_hit;
    logic         fifo_full, fifo_empty;
    logic [7:0]   fifo_head;
    logic [AW:0]  fifo_count;
    logic [31:0]  read_data_next;
    logic         unused_bits;

    assign uart_rw_address = UART_READ_ADDRESS;
    assign unused_bits     = ^{uart_read_data[31:8], bus.write_data[7:2]};

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (uart_irq) state_next = ST_REQ;
            ST_REQ:    state_next = ST_WAIT;
            ST_WAIT:   if (uart_read_response) state_next = ST_ACK;
            ST_ACK:    state_next = ST_SETTLE;
            // Give the UART a cycle to drop irq so the same byte is not re-read.
            ST_SETTLE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        uart_read_request = (state == ST_REQ);
        uart_irq_response = (state == ST_ACK);
        push              = (state == ST_WAIT) && uart_read_response;
    end

    assign rd_data_hit   = bus.read_request  && (bus.rw_address == DATA_ADDRESS);
    assign rd_status_hit = bus.read_request  && (bus.rw_address == STATUS_ADDRESS);
    assign wr_status_hit = bus.write_request && (bus.rw_address == STATUS_ADDRESS);
    assign pop           = rd_data_hit && !fifo_empty;
    assign flush         = wr_status_hit && bus.write_data[CTRL_FLUSH];
    assign clr_ovf       = wr_status_hit && bus.write_data[CTRL_CLR_OVF];

    always_comb begin
        read_data_next = '0;
        if (pop)
            read_data_next = {23'b0, 1'b1, fifo_head};
        else if (rd_status_hit)
            read_data_next = status_word(8'(fifo_count), overflow, fifo_full, fifo_empty);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.read_data      <= '0;
            bus.read_response  <= 1'b0;
            bus.write_response <= 1'b0;
            overflow           <= 1'b0;
            rx_irq             <= 1'b0;
        end else begin
            bus.read_data      <= read_data_next;
            bus.read_response  <= bus.read_request;
            bus.write_response <= bus.write_request;
            // A dropped byte outranks a same-cycle clear; a flushed byte is not a drop.
            if (push && fifo_full && !flush) overflow <= 1'b1;
            else if (clr_ovf)                overflow <= 1'b0;
            rx_irq             <= (fifo_count >= IRQ_LEVEL);
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (uart_read_data[7:0]),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: behavioural UART, queue reference model, directed and random scenarios.
module tb_uart_rx_fifo;
    localparam int          DEPTH     = 16;
    localparam logic [31:0] UART_ADDR = 32'h80000004;
    localparam logic [31:0] DATA_ADDR = 32'h80000010;
    localparam logic [31:0] STAT_ADDR = 32'h80000014;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] uart_rw_address, uart_read_data;
    logic        uart_read_request, uart_read_response, uart_irq, uart_irq_response, rx_irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] uart_q[$];
    logic [7:0] ref_q[$];
    logic       ref_ovf = 1'b0;
    int         req_cnt = 0;
    int         ack_cnt = 0;
    logic       pend;

    uart_rx_fifo_if cpu ();

    uart_rx_fifo #(
        .FIFO_DEPTH        (DEPTH),
        .IRQ_THRESHOLD     (1),
        .UART_READ_ADDRESS (UART_ADDR),
        .DATA_ADDRESS      (DATA_ADDR),
        .STATUS_ADDRESS    (STAT_ADDR)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .uart_rw_address    (uart_rw_address),
        .uart_read_request  (uart_read_request),
        .uart_read_data     (uart_read_data),
        .uart_read_response (uart_read_response),
        .uart_irq           (uart_irq),
        .uart_irq_response  (uart_irq_response),
        .bus                (cpu),
        .rx_irq             (rx_irq)
    );

    always #5 clock = ~clock;

    // UART: holds irq per byte, answers a read one cycle later, drops irq on ack.
    initial begin
        uart_irq = 1'b0;
        uart_read_response = 1'b0;
        uart_read_data = '0;
        pend = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (!reset_n) begin
                pend = 1'b0;
                uart_read_response = 1'b0;
            end else begin
                uart_read_response = pend;
                pend = uart_read_request;
                if (uart_read_request) req_cnt++;
                if (uart_irq_response) begin
                    ack_cnt++;
                    if (uart_q.size() > 0) void'(uart_q.pop_front());
                    uart_irq = 1'b0;
                end else if (!uart_irq && uart_q.size() > 0) begin
                    uart_irq = 1'b1;
                    uart_read_data = {24'($urandom), uart_q[0]};
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    function automatic logic [31:0] exp_status();
        return {16'h0, 8'(ref_q.size()), 5'b0, ref_ovf, ref_q.size() == DEPTH, ref_q.size() == 0};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        uart_q.push_back(b);
        if (ref_q.size() < DEPTH) ref_q.push_back(b);
        else ref_ovf = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((uart_q.size() != 0 || uart_irq) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d irq=%b required pending=0", uart_q.size(), uart_irq);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_read_response();
        int n = 0;
        @(negedge clock);
        while (!uart_read_response && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL uart_response_timeout: got none within %0d cycles", n);
        end
    endtask

    task automatic cpu_read(input logic [31:0] addr, output logic [31:0] data, output logic resp);
        @(negedge clock);
        cpu.rw_address = addr;
        cpu.read_request = 1'b1;
        @(negedge clock);
        cpu.read_request = 1'b0;
        cpu.rw_address = '0;
        data = cpu.read_data;
        resp = cpu.read_response;
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [7:0] wd, output logic resp);
        @(negedge clock);
        cpu.rw_address = addr;
        cpu.write_data = wd;
        cpu.write_request = 1'b1;
        @(negedge clock);
        cpu.write_request = 1'b0;
        cpu.rw_address = '0;
        cpu.write_data = '0;
        resp = cpu.write_response;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        r;
        repeat (3) @(negedge clock);
        checks++;
        if ({uart_read_request, uart_irq_response, rx_irq, cpu.read_response, cpu.write_response} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {uart_read_request, uart_irq_response, rx_irq, cpu.read_response, cpu.write_response});
        end
        checks++;
        if (cpu.read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_read_data: got %h required 00000000", cpu.read_data);
        end
        checks++;
        if (uart_rw_address !== UART_ADDR) begin
            errors++;
            $display("FAIL reset_uart_addr: got %h required %h", uart_rw_address, UART_ADDR);
        end
        reset_n = 1'b1;
        cpu_read(STAT_ADDR, d, r);
        checks++;
        if ({r, d} !== {1'b1, 32'h00000001}) begin
            errors++;
            $display("FAIL reset_status: got resp=%b data=%h required resp=1 data=00000001", r, d);
        end
    endtask

    task automatic test_single_byte();
        logic [31:0] d;
        logic        r;
        int          r0 = req_cnt;
        int          a0 = ack_cnt;
        send_byte(8'hA5);
        wait_idle();
        checks++;
        if (req_cnt - r0 != 1 || ack_cnt - a0 != 1) begin
            errors++;
            $display("FAIL single_handshake: got req=%0d ack=%0d required 1 1", req_cnt - r0, ack_cnt - a0);
        end
        checks++;
        if (rx_irq !== 1'b1) begin
            errors++;
            $display("FAIL single_irq_high: got %b required 1", rx_irq);
        end
        cpu_read(STAT_ADDR, d, r);
        checks++;
        if (d !== 32'h00000100) begin
            errors++;
            $display("FAIL single_status: got %h required 00000100", d);
        end
        cpu_read(DATA_ADDR, d, r);
        void'(ref_q.pop_front());
        checks++;
        if ({r, d} !== {1'b1, 32'h000001A5}) begin
            errors++;
            $display("FAIL single_data: got resp=%b data=%h required resp=1 data=000001a5", r, d);
        end
        cpu_read(STAT_ADDR, d, r);
        checks++;
        if (d !== 32'h00000001) begin
            errors++;
            $display("FAIL single_status_after: got %h required 00000001", d);
        end
        checks++;
        if (rx_irq !== 1'b0) begin
            errors++;
            $display("FAIL single_irq_low: got %b required 0", rx_irq);
        end
    endtask

    task automatic test_order_wrap();
        logic [31:0] d, e;
        logic        r;
        for (int i = 0; i < 40; i++) begin
            send_byte(8'(i));
            wait_idle();
            if (ref_q.size() >= 8) begin
                for (int k = 0; k < 8; k++) begin
                    cpu_read(DATA_ADDR, d, r);
                    e = {23'b0, 1'b1, ref_q.pop_front()};
                    checks++;
                    if (d !== e) begin
                        errors++;
                        $display("FAIL order_data[%0d]: got %h required %h", i, d, e);
                    end
                end
            end
        end
        cpu_read(STAT_ADDR, d, r);
        checks++;
        if (d !== 32'h00000001) begin
            errors++;
            $display("FAIL order_status_end: got %h required 00000001", d);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d, e;
        logic        r;
        int          a0 = ack_cnt;
        for (int i = 0; i < 17; i++) send_byte(8'($urandom));
        wait_idle();
        checks++;
        if (ack_cnt - a0 != 17) begin
            errors++;
            $display("FAIL ovf_acks: got %0d required 17", ack_cnt - a0);
        end
        cpu_read(STAT_ADDR, d, r);
        checks++;
        if (d !== 32'h00001006) begin
            errors++;
            $display("FAIL ovf_status: got %h required 00001006", d);
        end
        cpu_write(STAT_ADDR, 8'h01, r);
        ref_ovf = 1'b0;
        checks++;
        if (r !== 1'b1) begin
            errors++;
            $display("FAIL ovf_write_resp: got %b required 1", r);
        end
        cpu_read(STAT_ADDR, d, r);
        checks++;
        if (d !== 32'h00001002) begin
            errors++;
            $display("FAIL ovf_status_cleared: got %h required 00001002", d);
        end
        for (int k = 0; k < DEPTH; k++) begin
            cpu_read(DATA_ADDR, d, r);
            e = {23'b0, 1'b1, ref_q.pop_front()};
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL ovf_data[%0d]: got %h required %h", k, d, e);
            end
        end
    endtask

    task automatic test_empty_pop();
        logic [31:0] d;
        logic        r;
        cpu_read(DATA_ADDR, d, r);
        checks++;
        if ({r, d} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL empty_pop: got resp=%b data=%h required resp=1 data=00000000", r, d);
        end
        cpu_read(STAT_ADDR, d, r);
        checks++;
        if (d !== 32'h00000001) begin
            errors++;
            $display("FAIL empty_pop_status: got %h required 00000001", d);
        end
        cpu_read(32'h80000020, d, r);
        checks++;
        if ({r, d} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL unmapped_read: got resp=%b data=%h required resp=1 data=00000000", r, d);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d, e;
        logic        r;
        logic [7:0]  b;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        wait_idle();
        b = 8'($urandom);
        uart_q.push_back(b);
        wait_read_response();
        cpu.rw_address = DATA_ADDR;
        cpu.read_request = 1'b1;
        @(negedge clock);
        cpu.read_request = 1'b0;
        cpu.rw_address = '0;
        d = cpu.read_data;
        e = {23'b0, 1'b1, ref_q.pop_front()};
        ref_q.push_back(b);
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL pushpop_data: got %h required %h", d, e);
        end
        wait_idle();
        cpu_read(STAT_ADDR, d, r);
        checks++;
        if (d !== 32'h00000300) begin
            errors++;
            $display("FAIL pushpop_status: got %h required 00000300", d);
        end
        uart_q.push_back(8'($urandom));
        wait_read_response();
        cpu.rw_address = STAT_ADDR;
        cpu.write_data = 8'h02;
        cpu.write_request = 1'b1;
        @(negedge clock);
        cpu.write_request = 1'b0;
        cpu.rw_address = '0;
        cpu.write_data = '0;
        r = cpu.write_response;
        ref_q.delete();
        checks++;
        if (r !== 1'b1) begin
            errors++;
            $display("FAIL flushpush_resp: got %b required 1", r);
        end
        wait_idle();
        cpu_read(STAT_ADDR, d, r);
        checks++;
        if (d !== 32'h00000001) begin
            errors++;
            $display("FAIL flushpush_status: got %h required 00000001", d);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d, e;
        logic        r;
        logic [7:0]  b;
        int          r0;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        wait_idle();
        cpu_read(STAT_ADDR, d, r);
        checks++;
        if (d !== 32'h00000500) begin
            errors++;
            $display("FAIL areset_prefill: got %h required 00000500", d);
        end
        b = 8'($urandom);
        uart_q.push_back(b);
        wait_read_response();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({uart_read_request, uart_irq_response, rx_irq, cpu.read_response, cpu.write_response, cpu.read_data} !== 37'b0) begin
            errors++;
            $display("FAIL areset_outputs: got req=%b ack=%b irq=%b rresp=%b wresp=%b data=%h required all 0",
                     uart_read_request, uart_irq_response, rx_irq, cpu.read_response, cpu.write_response, cpu.read_data);
        end
        repeat (3) @(negedge clock);
        r0 = req_cnt;
        reset_n = 1'b1;
        ref_q.delete();
        ref_ovf = 1'b0;
        ref_q.push_back(b);
        wait_idle();
        checks++;
        if (req_cnt - r0 != 1) begin
            errors++;
            $display("FAIL areset_reread: got %0d requests required 1", req_cnt - r0);
        end
        cpu_read(STAT_ADDR, d, r);
        checks++;
        if (d !== 32'h00000100) begin
            errors++;
            $display("FAIL areset_status: got %h required 00000100", d);
        end
        cpu_read(DATA_ADDR, d, r);
        e = {23'b0, 1'b1, ref_q.pop_front()};
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL areset_data: got %h required %h", d, e);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, e;
        logic        r;
        logic [7:0]  w;
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: begin
                    send_byte(8'($urandom));
                    wait_idle();
                end
                3: begin
                    cpu_read(DATA_ADDR, d, r);
                    e = (ref_q.size() == 0) ? 32'h0 : {23'b0, 1'b1, ref_q.pop_front()};
                    checks++;
                    if (d !== e) begin
                        errors++;
                        $display("FAIL rand_data[%0d]: got %h required %h", i, d, e);
                    end
                end
                4: begin
                    cpu_read(STAT_ADDR, d, r);
                    e = exp_status();
                    checks++;
                    if (d !== e || rx_irq !== (ref_q.size() >= 1)) begin
                        errors++;
                        $display("FAIL rand_status[%0d]: got %h irq=%b required %h irq=%b",
                                 i, d, rx_irq, e, ref_q.size() >= 1);
                    end
                end
                default: begin
                    w = 8'($urandom_range(0, 3));
                    if ($urandom_range(0, 3) != 0) w[1] = 1'b0;
                    cpu_write(STAT_ADDR, w, r);
                    if (w[0]) ref_ovf = 1'b0;
                    if (w[1]) ref_q.delete();
                end
            endcase
        end
        cpu_read(STAT_ADDR, d, r);
        e = exp_status();
        checks++;
        if (d !== e) begin
            errors++;
            $display("FAIL rand_status_end: got %h required %h", d, e);
        end
    endtask

    initial begin
        cpu.rw_address = '0;
        cpu.read_request = 1'b0;
        cpu.write_data = '0;
        cpu.write_request = 1'b0;
        test_reset();
        test_single_byte();
        test_order_wrap();
        test_overflow();
        test_empty_pop();
        test_same_cycle();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
